// File: rtl/bbox_scanner.sv
// Purpose : streams an IMG_W x IMG_H x CHANNELS image from pixel memory and reports the
//           bounding box, count and empty flag of its foreground pixels.
// Latency : first rd_req one cycle after start; done IMG_W*IMG_H*CHANNELS + RD_LAT + 1 cycles after start.
// Backpressure: none; one read per SCAN cycle, memory must accept every request.
// Ports   : clk/rst_n (sync, active-low); start/abort control; base_addr/threshold/polarity
//           latched at start; rd_req/addr/rd_data memory port; busy/done status;
//           empty, x_min..y_max, fg_count hold the last completed result.
module bbox_scanner #(
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int COORD_W  = 11
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ADDR_W-1:0]                     base_addr,
    input  logic [DATA_W-1:0]                     threshold,
    input  logic                                  polarity,
    output logic                                  rd_req,
    output logic [ADDR_W-1:0]                     addr,
    input  logic [DATA_W-1:0]                     rd_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  empty,
    output logic [COORD_W-1:0]                    x_min,
    output logic [COORD_W-1:0]                    x_max,
    output logic [COORD_W-1:0]                    y_min,
    output logic [COORD_W-1:0]                    y_max,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0]      fg_count
);

    localparam int CNT_W = $clog2(IMG_W*IMG_H+1);
    localparam int C_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W-1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H-1);
    localparam logic [C_W-1:0]     C_LAST = C_W'(CHANNELS-1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_thr;
    logic                r_pol;
    logic [COORD_W-1:0]  r_x, r_y;
    logic [C_W-1:0]      r_c;

    // Return-path tags, stage RD_LAT-1 lines up with rd_data.
    logic                r_tag_vld [RD_LAT];
    logic [COORD_W-1:0]  r_tag_x   [RD_LAT];
    logic [COORD_W-1:0]  r_tag_y   [RD_LAT];
    logic                r_tag_lc  [RD_LAT];

    logic                r_or;
    logic [COORD_W-1:0]  r_min_x, r_max_x, r_min_y, r_max_y;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_empty;
    logic [COORD_W-1:0]  r_x_min, r_x_max, r_y_min, r_y_max;
    logic [CNT_W-1:0]    r_fg_count;

    logic                w_start_ok, w_abort, w_last_req;
    logic                w_tag_vld, w_tag_lc, w_hit, w_pix_fg, w_last_ret, w_load_res;
    logic [COORD_W-1:0]  w_tx, w_ty;
    logic [COORD_W-1:0]  w_min_x_nxt, w_max_x_nxt, w_min_y_nxt, w_max_y_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Abort beats start when both arrive together.
    assign w_start_ok = start & ~abort & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_abort    = abort & ((r_state == S_SCAN) | (r_state == S_DRAIN));
    assign w_last_req = (r_state == S_SCAN) & (r_x == X_LAST) & (r_y == Y_LAST) & (r_c == C_LAST);

    assign w_tag_vld  = r_tag_vld[RD_LAT-1];
    assign w_tag_lc   = r_tag_lc[RD_LAT-1];
    assign w_tx       = r_tag_x[RD_LAT-1];
    assign w_ty       = r_tag_y[RD_LAT-1];
    assign w_hit      = r_pol ? (rd_data > r_thr) : (rd_data < r_thr);
    assign w_pix_fg   = w_tag_vld & w_tag_lc & (r_or | w_hit);
    assign w_last_ret = w_tag_vld & w_tag_lc & (w_tx == X_LAST) & (w_ty == Y_LAST);
    assign w_load_res = (r_state == S_DRAIN) & ~abort & w_last_ret;

    // Next accumulator values; results load from these so the final pixel is included.
    always_comb begin
        w_min_x_nxt = r_min_x;
        w_max_x_nxt = r_max_x;
        w_min_y_nxt = r_min_y;
        w_max_y_nxt = r_max_y;
        w_cnt_nxt   = r_cnt;
        if (w_pix_fg) begin
            if (w_tx < r_min_x) w_min_x_nxt = w_tx;
            if (w_tx > r_max_x) w_max_x_nxt = w_tx;
            if (w_ty < r_min_y) w_min_y_nxt = w_ty;
            if (w_ty > r_max_y) w_max_y_nxt = w_ty;
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_SCAN;
            S_SCAN:  if (abort) w_state_nxt = S_IDLE; else if (w_last_req) w_state_nxt = S_DRAIN;
            S_DRAIN: if (abort) w_state_nxt = S_IDLE; else if (w_last_ret) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_thr      <= '0;
            r_pol      <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_c        <= '0;
            r_or       <= 1'b0;
            r_min_x    <= '0;
            r_max_x    <= '0;
            r_min_y    <= '0;
            r_max_y    <= '0;
            r_cnt      <= '0;
            r_empty    <= 1'b0;
            r_x_min    <= '0;
            r_x_max    <= '0;
            r_y_min    <= '0;
            r_y_max    <= '0;
            r_fg_count <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_x[i]   <= '0;
                r_tag_y[i]   <= '0;
                r_tag_lc[i]  <= 1'b0;
            end
        end else begin
            r_state <= w_state_nxt;

            // Scan order is x, y, channel; the linear address therefore just increments.
            if (w_start_ok) begin
                r_addr <= base_addr;
                r_thr  <= threshold;
                r_pol  <= polarity;
                r_x    <= '0;
                r_y    <= '0;
                r_c    <= '0;
            end else if (r_state == S_SCAN) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_c == C_LAST) begin
                    r_c <= '0;
                    if (r_y == Y_LAST) begin
                        r_y <= '0;
                        r_x <= r_x + COORD_W'(1);
                    end else begin
                        r_y <= r_y + COORD_W'(1);
                    end
                end else begin
                    r_c <= r_c + C_W'(1);
                end
            end

            if (w_abort) begin
                for (int i = 0; i < RD_LAT; i++) r_tag_vld[i] <= 1'b0;
            end else begin
                r_tag_vld[0] <= (r_state == S_SCAN);
                r_tag_x[0]   <= r_x;
                r_tag_y[0]   <= r_y;
                r_tag_lc[0]  <= (r_c == C_LAST);
                for (int i = 1; i < RD_LAT; i++) begin
                    r_tag_vld[i] <= r_tag_vld[i-1];
                    r_tag_x[i]   <= r_tag_x[i-1];
                    r_tag_y[i]   <= r_tag_y[i-1];
                    r_tag_lc[i]  <= r_tag_lc[i-1];
                end
            end

            if (w_start_ok) begin
                r_or    <= 1'b0;
                r_min_x <= X_LAST;
                r_min_y <= Y_LAST;
                r_max_x <= '0;
                r_max_y <= '0;
                r_cnt   <= '0;
            end else begin
                r_min_x <= w_min_x_nxt;
                r_max_x <= w_max_x_nxt;
                r_min_y <= w_min_y_nxt;
                r_max_y <= w_max_y_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_tag_vld) r_or <= w_tag_lc ? 1'b0 : (r_or | w_hit);
            end

            if (w_load_res) begin
                if (w_cnt_nxt == '0) begin
                    r_empty    <= 1'b1;
                    r_x_min    <= '0;
                    r_x_max    <= '0;
                    r_y_min    <= '0;
                    r_y_max    <= '0;
                    r_fg_count <= '0;
                end else begin
                    r_empty    <= 1'b0;
                    r_x_min    <= w_min_x_nxt;
                    r_x_max    <= w_max_x_nxt;
                    r_y_min    <= w_min_y_nxt;
                    r_y_max    <= w_max_y_nxt;
                    r_fg_count <= w_cnt_nxt;
                end
            end
        end
    end

    assign rd_req   = (r_state == S_SCAN);
    assign addr     = r_addr;
    assign busy     = (r_state == S_SCAN) | (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign empty    = r_empty;
    assign x_min    = r_x_min;
    assign x_max    = r_x_max;
    assign y_min    = r_y_min;
    assign y_max    = r_y_max;
    assign fg_count = r_fg_count;

endmodule

// File: tb/tb_bbox_scanner.sv
// Purpose : self-checking bench for bbox_scanner; two instances (RD_LAT 1 and 4) share stimulus.
// Latency : expects done at start + N + RD_LAT + 1 for each instance.
// Backpressure: memory model answers every request after the instance's RD_LAT.
module tb_bbox_scanner;

    localparam int W = 8, H = 8, C = 3, DW = 16, AW = 32, CW = 11, CNTW = 7;
    localparam int N = W * H * C;

    typedef struct packed {
        logic          empty;
        logic [CW-1:0] x_min, x_max, y_min, y_max;
        logic [CNTW-1:0] cnt;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, polarity;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] threshold;

    logic rd_req1, busy1, done1, empty1, rd_req4, busy4, done4, empty4;
    logic [AW-1:0] addr1, addr4;
    logic [DW-1:0] rd_data1, rd_data4;
    logic [DW-1:0] p4 [4];
    logic [CW-1:0] xmn1, xmx1, ymn1, ymx1, xmn4, xmx4, ymn4, ymx4;
    logic [CNTW-1:0] fg1, fg4;
    res_t obs1, obs4;

    assign obs1 = {empty1, xmn1, xmx1, ymn1, ymx1, fg1};
    assign obs4 = {empty4, xmn4, xmx4, ymn4, ymx4, fg4};
    assign rd_data4 = p4[3];

    bbox_scanner #(.IMG_W(W), .IMG_H(H), .CHANNELS(C), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COORD_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .threshold(threshold), .polarity(polarity), .rd_req(rd_req1), .addr(addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .empty(empty1), .x_min(xmn1), .x_max(xmx1), .y_min(ymn1),
        .y_max(ymx1), .fg_count(fg1));

    bbox_scanner #(.IMG_W(W), .IMG_H(H), .CHANNELS(C), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(4), .COORD_W(CW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .threshold(threshold), .polarity(polarity), .rd_req(rd_req4), .addr(addr4), .rd_data(rd_data4),
        .busy(busy4), .done(done4), .empty(empty4), .x_min(xmn4), .x_max(xmx4), .y_min(ymn4),
        .y_max(ymx4), .fg_count(fg4));

    // Image held as a flat word array at offset (x*H + y)*C + c from the scan base.
    logic [DW-1:0] img [N];
    logic [AW-1:0] mbase;
    int checks = 0, errors = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - mbase;
        if (off < AW'(N)) return img[off];
        return 16'hDEAD;
    endfunction

    // Idle cycles return noise so the DUT must ignore untagged data.
    always @(posedge clk) begin
        rd_data1 <= rd_req1 ? mem_rd(addr1) : DW'($urandom);
        p4[0]    <= rd_req4 ? mem_rd(addr4) : DW'($urandom);
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end

    function automatic res_t mk(input logic e, input int x0, input int x1, input int y0, input int y1, input int n);
        res_t r;
        r.empty = e; r.x_min = CW'(x0); r.x_max = CW'(x1); r.y_min = CW'(y0); r.y_max = CW'(y1); r.cnt = CNTW'(n);
        return r;
    endfunction

    function automatic res_t ref_model(input logic [DW-1:0] thr, input logic pol);
        int n = 0, x0 = W, x1 = -1, y0 = H, y1 = -1;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) begin
                bit fg = 0;
                for (int c = 0; c < C; c++) begin
                    int w = int'(img[(x*H + y)*C + c]);
                    if (pol ? (w > int'(thr)) : (w < int'(thr))) fg = 1;
                end
                if (fg) begin
                    n++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
            end
        if (n == 0) return mk(1'b1, 0, 0, 0, 0, 0);
        return mk(1'b0, x0, x1, y0, y1, n);
    endfunction

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic fill_sparse(input logic [DW-1:0] thr);
        for (int i = 0; i < N; i++) begin
            int r = int'($urandom_range(0, 39));
            img[i] = (r == 0) ? thr - 16'd1 : (r == 1) ? thr + 16'd1 : thr;
        end
    endtask

    // Runs one scan from IDLE/DONE. Checks request count, address order, latency and
    // that the previous result holds until done; results are left on obs1/obs4.
    task automatic do_scan(input string name, input logic [AW-1:0] base, input logic [DW-1:0] thr, input logic pol);
        int lat1 = -1, lat4 = -1, nreq1 = 0, nreq4 = 0, addr_bad = 0, hold_bad = 0;
        res_t prev1 = obs1, prev4 = obs4;
        @(negedge clk);
        base_addr = base; threshold = thr; polarity = pol; mbase = base; start = 1'b1;
        for (int k = 1; k <= 400 && (lat1 < 0 || lat4 < 0); k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; base_addr = $urandom; threshold = DW'($urandom); polarity = 1'($urandom);
            end
            if (k == 20) start = 1'b1;
            if (k == 21) start = 1'b0;
            if (rd_req1) begin if (addr1 !== base + AW'(nreq1)) addr_bad++; nreq1++; end
            if (rd_req4) begin if (addr4 !== base + AW'(nreq4)) addr_bad++; nreq4++; end
            if (lat1 < 0) begin if (done1) lat1 = k; else if (obs1 !== prev1) hold_bad++; end
            if (lat4 < 0) begin if (done4) lat4 = k; else if (obs4 !== prev4) hold_bad++; end
        end
        checks += 6;
        if (lat1 !== N + 2) begin errors++; $display("FAIL %s latency1: got %0d want %0d", name, lat1, N + 2); end
        if (lat4 !== N + 5) begin errors++; $display("FAIL %s latency4: got %0d want %0d", name, lat4, N + 5); end
        if (nreq1 !== N) begin errors++; $display("FAIL %s nreq1: got %0d want %0d", name, nreq1, N); end
        if (nreq4 !== N) begin errors++; $display("FAIL %s nreq4: got %0d want %0d", name, nreq4, N); end
        if (addr_bad !== 0) begin errors++; $display("FAIL %s addr: got %0d bad want 0", name, addr_bad); end
        if (hold_bad !== 0) begin errors++; $display("FAIL %s hold: got %0d changes want 0", name, hold_bad); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; polarity = 1'b0; base_addr = '0; threshold = '0; mbase = '0;
        fill(16'hFFFF);
        repeat (3) @(negedge clk);
        checks += 3;
        if ({rd_req1, busy1, done1, rd_req4, busy4, done4} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {rd_req1, busy1, done1, rd_req4, busy4, done4});
        end
        if (obs1 !== '0) begin errors++; $display("FAIL reset_res1: got %h want 0", obs1); end
        if (obs4 !== '0) begin errors++; $display("FAIL reset_res4: got %h want 0", obs4); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pixel();
        res_t e;
        fill(16'd255);
        img[(3*H + 5)*C] = 16'd10;
        e = ref_model(16'd250, 1'b0);
        do_scan("single", 32'h0, 16'd250, 1'b0);
        checks += 3;
        if (e !== mk(1'b0, 3, 3, 5, 5, 1)) begin errors++; $display("FAIL single_model: got %h want %h", e, mk(1'b0, 3, 3, 5, 5, 1)); end
        if (obs1 !== e) begin errors++; $display("FAIL single_res1: got %h want %h", obs1, e); end
        if (obs4 !== e) begin errors++; $display("FAIL single_res4: got %h want %h", obs4, e); end
    endtask

    task automatic test_all_background();
        fill(16'd255);
        do_scan("allbg", 32'h40, 16'd250, 1'b0);
        checks += 2;
        if (obs1 !== mk(1'b1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL allbg_res1: got %h want empty", obs1); end
        if (obs4 !== mk(1'b1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL allbg_res4: got %h want empty", obs4); end
    endtask

    task automatic test_corners();
        fill(16'd255);
        img[1] = 16'd0;
        img[(7*H + 7)*C + 2] = 16'd0;
        do_scan("corners", 32'h0, 16'd250, 1'b0);
        checks += 2;
        if (obs1 !== mk(1'b0, 0, 7, 0, 7, 2)) begin errors++; $display("FAIL corners_res1: got %h want %h", obs1, mk(1'b0, 0, 7, 0, 7, 2)); end
        if (obs4 !== mk(1'b0, 0, 7, 0, 7, 2)) begin errors++; $display("FAIL corners_res4: got %h want %h", obs4, mk(1'b0, 0, 7, 0, 7, 2)); end
    endtask

    task automatic test_polarity();
        fill(16'd0);
        do_scan("pol1", 32'h1000, 16'd0, 1'b1);
        checks += 2;
        if (obs1 !== mk(1'b1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL pol1_res1: got %h want empty", obs1); end
        if (obs4 !== mk(1'b1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL pol1_res4: got %h want empty", obs4); end
        do_scan("pol0", 32'h1000, 16'd1, 1'b0);
        checks += 2;
        if (obs1 !== mk(1'b0, 0, 7, 0, 7, 64)) begin errors++; $display("FAIL pol0_res1: got %h want full", obs1); end
        if (obs4 !== mk(1'b0, 0, 7, 0, 7, 64)) begin errors++; $display("FAIL pol0_res4: got %h want full", obs4); end
    endtask

    task automatic test_abort();
        res_t prev1 = obs1, prev4 = obs4, e;
        logic [DW-1:0] thr = 16'd3000;
        fill_sparse(thr);
        @(negedge clk);
        base_addr = 32'h0; threshold = 16'd1; polarity = 1'b0; mbase = 32'h0; start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks += 1;
        if ({rd_req1, busy1, done1, rd_req4, busy4, done4} !== 6'b0) begin
            errors++; $display("FAIL abort_ctrl: got %b want 000000", {rd_req1, busy1, done1, rd_req4, busy4, done4});
        end
        repeat (8) @(negedge clk);
        checks += 3;
        if (obs1 !== prev1) begin errors++; $display("FAIL abort_hold1: got %h want %h", obs1, prev1); end
        if (obs4 !== prev4) begin errors++; $display("FAIL abort_hold4: got %h want %h", obs4, prev4); end
        if ({busy1, done1, busy4, done4} !== 4'b0) begin errors++; $display("FAIL abort_idle: got %b want 0000", {busy1, done1, busy4, done4}); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks += 1;
        if ({rd_req1, busy1, rd_req4, busy4} !== 4'b0) begin errors++; $display("FAIL abort_start: got %b want 0000", {rd_req1, busy1, rd_req4, busy4}); end
        e = ref_model(thr, 1'b0);
        do_scan("restart", 32'h200, thr, 1'b0);
        checks += 2;
        if (obs1 !== e) begin errors++; $display("FAIL restart_res1: got %h want %h", obs1, e); end
        if (obs4 !== e) begin errors++; $display("FAIL restart_res4: got %h want %h", obs4, e); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [DW-1:0] thr = DW'($urandom_range(1, 65534));
            logic pol = 1'($urandom);
            logic [AW-1:0] base = (it == 0) ? 32'hFFFF_FF80 : $urandom;
            res_t e;
            fill_sparse(thr);
            e = ref_model(thr, pol);
            do_scan("random", base, thr, pol);
            checks += 2;
            if (obs1 !== e) begin errors++; $display("FAIL random%0d_res1: got %h want %h", it, obs1, e); end
            if (obs4 !== e) begin errors++; $display("FAIL random%0d_res4: got %h want %h", it, obs4, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_all_background();
        test_corners();
        test_polarity();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
